// File: rtl/ir_rx_pkg.sv
// Shared types, frame geometry and tick-count windows for the IR command receiver.
package ir_rx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SPACE = 3'd2,
        MARK  = 3'd3,
        DONE  = 3'd4
    } ir_state_e;

    localparam int FRAME_BITS = 12;

    // All windows are in sample ticks spent at one line level
    localparam logic [5:0] START_MIN = 6'd28;
    localparam logic [5:0] START_MAX = 6'd40;
    localparam logic [5:0] BIT_MIN   = 6'd4;
    localparam logic [5:0] ONE_MIN   = 6'd12;
    localparam logic [5:0] SPACE_MAX = 6'd12;
    localparam logic [5:0] MARK_MAX  = 6'd27;

    localparam int REPEAT_IDLE_TICKS = 1024;

    function automatic logic [5:0] sat_inc(input logic [5:0] value);
        return (value == 6'd63) ? value : value + 6'd1;
    endfunction

endpackage

// File: rtl/ir_command_receiver_if.sv
// IR receiver line in, decoded drive command and status pulses out.
interface ir_command_receiver_if;
    import ir_rx_pkg::*;

    logic                  ir_signal;
    logic [FRAME_BITS-1:0] command;
    logic                  command_ready;
    logic                  frame_error;

    modport master (output ir_signal, input command, input command_ready, input frame_error);
    modport slave  (input ir_signal, output command, output command_ready, output frame_error);

endinterface

// File: rtl/ir_sample_tick.sv
// Two-flop synchronizer for the raw IR line plus the free-running sample tick divider.
module ir_sample_tick #(
    parameter int TICK_DIV = 2025
) (
    input  logic clock,
    input  logic reset,
    input  logic ir_signal,
    output logic ir_s,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] div_r;

    // Synchronizer idles at the no-carrier level; divider wraps on its last count
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            div_r   <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= ir_signal;
            sync2_r <= sync1_r;
            div_r   <= (div_r == DIV_LAST) ? {CNT_W{1'b0}} : div_r + CNT_W'(1);
        end
    end

    assign ir_s = sync2_r;
    assign tick = (div_r == DIV_LAST);

endmodule

// File: rtl/ir_command_receiver.sv
// SIRC-style 12-bit IR frame decoder feeding motor_signal_stream.
// Optional IR_REPEAT_FILTER_EN: a command fires only when two consecutive frames agree.
module ir_command_receiver #(
    parameter int TICK_DIV = 2025
) (
    input  logic                  clock,
    input  logic                  reset,
    ir_command_receiver_if.slave  bus
);
    import ir_rx_pkg::*;

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    logic                  ir_s;
    logic                  tick_s;
    ir_state_e             state_r, state_n;
    logic [5:0]            cnt_r, cnt_n;
    logic [3:0]            bitcnt_r, bitcnt_n;
    logic [FRAME_BITS-1:0] shreg_r, shreg_n;
    logic [FRAME_BITS-1:0] command_r;
    logic                  ready_r;
    logic                  error_r;
    logic                  err_s;
    logic                  done_s;
    logic                  fire_s;

    ir_sample_tick #(.TICK_DIV(TICK_DIV)) u_sample_tick (
        .clock     (clock),
        .reset     (reset),
        .ir_signal (bus.ir_signal),
        .ir_s      (ir_s),
        .tick      (tick_s)
    );

    // State and width/bit counters, only advanced on sample ticks
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r  <= IDLE;
            cnt_r    <= 6'd0;
            bitcnt_r <= 4'd0;
            shreg_r  <= {FRAME_BITS{1'b0}};
        end else begin
            state_r  <= state_n;
            cnt_r    <= cnt_n;
            bitcnt_r <= bitcnt_n;
            shreg_r  <= shreg_n;
        end
    end

    // Next-state decode; cnt restarts at 1 on the tick that first sees a new level
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        bitcnt_n = bitcnt_r;
        shreg_n  = shreg_r;
        err_s    = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            // DONE behaves like IDLE so a new start mark costs no dead time
            IDLE, DONE: begin
                if (tick_s && !ir_s) begin
                    state_n = START;
                    cnt_n   = 6'd1;
                end else begin
                    state_n = IDLE;
                    cnt_n   = 6'd0;
                end
            end
            START: begin
                if (!tick_s) begin
                    state_n = START;
                end else if (!ir_s) begin
                    cnt_n = sat_inc(cnt_r);
                end else if (cnt_r >= START_MIN && cnt_r <= START_MAX) begin
                    state_n  = SPACE;
                    cnt_n    = 6'd1;
                    bitcnt_n = 4'd0;
                end else begin
                    state_n = IDLE;
                    cnt_n   = 6'd0;
                end
            end
            SPACE: begin
                if (!tick_s) begin
                    state_n = SPACE;
                end else if (ir_s && cnt_r >= SPACE_MAX) begin
                    err_s   = 1'b1;
                    state_n = IDLE;
                    cnt_n   = 6'd0;
                end else if (ir_s) begin
                    cnt_n = cnt_r + 6'd1;
                end else if (cnt_r >= BIT_MIN) begin
                    state_n = MARK;
                    cnt_n   = 6'd1;
                end else begin
                    err_s   = 1'b1;
                    state_n = IDLE;
                    cnt_n   = 6'd0;
                end
            end
            MARK: begin
                if (!tick_s) begin
                    state_n = MARK;
                end else if (!ir_s) begin
                    cnt_n = sat_inc(cnt_r);
                end else if (cnt_r < BIT_MIN || cnt_r > MARK_MAX) begin
                    err_s   = 1'b1;
                    state_n = IDLE;
                    cnt_n   = 6'd0;
                end else begin
                    shreg_n[bitcnt_r] = (cnt_r >= ONE_MIN);
                    bitcnt_n          = bitcnt_r + 4'd1;
                    if (bitcnt_r == LAST_BIT) begin
                        state_n = DONE;
                        cnt_n   = 6'd0;
                        done_s  = 1'b1;
                    end else begin
                        state_n = SPACE;
                        cnt_n   = 6'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 6'd0;
            end
        endcase
    end

`ifdef IR_REPEAT_FILTER_EN
    localparam int IDLE_W = $clog2(REPEAT_IDLE_TICKS);

    logic [FRAME_BITS-1:0] pend_r;
    logic                  pend_valid_r;
    logic [IDLE_W-1:0]     idle_cnt_r;

    // A frame only fires when it repeats the pending one
    always_comb begin
        fire_s = done_s && pend_valid_r && (shreg_n == pend_r);
    end

    // Pending frame tracking; errors and long idle periods forget it
    always_ff @(posedge clock) begin
        if (!reset) begin
            pend_r       <= {FRAME_BITS{1'b0}};
            pend_valid_r <= 1'b0;
            idle_cnt_r   <= {IDLE_W{1'b0}};
        end else if (err_s) begin
            pend_valid_r <= 1'b0;
            idle_cnt_r   <= {IDLE_W{1'b0}};
        end else if (done_s) begin
            idle_cnt_r <= {IDLE_W{1'b0}};
            if (fire_s) begin
                pend_valid_r <= 1'b0;
            end else begin
                pend_r       <= shreg_n;
                pend_valid_r <= 1'b1;
            end
        end else if (state_r != IDLE) begin
            idle_cnt_r <= {IDLE_W{1'b0}};
        end else if (tick_s && idle_cnt_r == IDLE_W'(REPEAT_IDLE_TICKS - 1)) begin
            pend_valid_r <= 1'b0;
            idle_cnt_r   <= {IDLE_W{1'b0}};
        end else if (tick_s) begin
            idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end
`else
    // Every valid frame fires
    always_comb begin
        fire_s = done_s;
    end
`endif

    // Registered outputs; command survives errors and holds between frames
    always_ff @(posedge clock) begin
        if (!reset) begin
            command_r <= {FRAME_BITS{1'b0}};
            ready_r   <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            ready_r   <= fire_s;
            error_r   <= err_s;
            command_r <= fire_s ? shreg_n : command_r;
        end
    end

    assign bus.command       = command_r;
    assign bus.command_ready = ready_r;
    assign bus.frame_error   = error_r;

endmodule

// File: tb/tb_ir_command_receiver.sv
// Randomized self-checking bench for ir_command_receiver against a frame-level reference model.
module tb_ir_command_receiver;

    localparam int TICK_DIV = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    ir_command_receiver_if bus();

    ir_command_receiver #(.TICK_DIV(TICK_DIV)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int ready_seen = 0;
    int err_seen = 0;
    int exp_ready = 0;
    int exp_err = 0;
    logic [11:0] exp_q[$];
    logic [11:0] model_cmd = 12'h000;
    logic [11:0] pend_m = 12'h000;
    bit          pend_v = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: pulse exclusivity, latency from the final rising edge, value at pulse
    always @(negedge clock) begin
        if (reset) begin
            if (bus.command_ready || bus.frame_error)
                check_eq("ready_err_exclusive", 32'(bus.command_ready & bus.frame_error), 32'd0);
            if (bus.frame_error) err_seen++;
            if (bus.command_ready) begin
                ready_seen++;
                check_eq("ready_latency_3_to_6",
                         32'((cyc - last_rise_cyc) >= 3 && (cyc - last_rise_cyc) <= 6), 32'd1);
                if (exp_q.size() == 0) check_eq("unexpected_ready", 32'd1, 32'd0);
                else check_eq("cmd_at_ready", 32'(bus.command), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic int rnd(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    // Reference model: what a correctly received frame or a discarded frame should produce
    task automatic model_valid(input logic [11:0] d);
`ifdef IR_REPEAT_FILTER_EN
        if (pend_v && pend_m == d) begin
            pend_v = 1'b0;
            exp_q.push_back(d);
            exp_ready++;
            model_cmd = d;
        end else begin
            pend_m = d;
            pend_v = 1'b1;
        end
`else
        exp_q.push_back(d);
        exp_ready++;
        model_cmd = d;
`endif
    endtask

    task automatic model_error();
        pend_v = 1'b0;
        exp_err++;
    endtask

    // Hold the line at one level for a whole number of sample ticks
    task automatic seg(input logic lvl, input int ticks);
        if (lvl && !bus.ir_signal) last_rise_cyc = cyc;
        bus.ir_signal = lvl;
        repeat (ticks * TICK_DIV) @(posedge clock);
        #1;
    endtask

    task automatic send_start(input bit jit);
        seg(1'b0, jit ? rnd(28, 40) : 32);
    endtask

    task automatic send_bits(input logic [11:0] d, input int nbits, input bit jit);
        for (int i = 0; i < nbits; i++) begin
            seg(1'b1, jit ? rnd(4, 12) : 8);
            if (d[i]) seg(1'b0, jit ? rnd(12, 27) : 16);
            else      seg(1'b0, jit ? rnd(4, 11) : 8);
        end
    endtask

    task automatic send_frame(input logic [11:0] d, input int gap, input bit jit);
        model_valid(d);
        send_start(jit);
        send_bits(d, 12, jit);
        seg(1'b1, gap);
    endtask

    task automatic checkpoint(input string tag);
        check_eq({tag, "_ready_count"}, 32'(ready_seen), 32'(exp_ready));
        check_eq({tag, "_error_count"}, 32'(err_seen), 32'(exp_err));
        check_eq({tag, "_command"}, 32'(bus.command), 32'(model_cmd));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [11:0] d;
        logic [11:0] last_d;
        int kind;
        int k;

        // Reset and idle
        bus.ir_signal = 1'b1;
        reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        check_eq("reset_command", 32'(bus.command), 32'h000);
        check_eq("reset_ready", 32'(bus.command_ready), 32'd0);
        check_eq("reset_error", 32'(bus.frame_error), 32'd0);
        repeat (1000) @(posedge clock);
        #1;
        checkpoint("idle");

        send_frame(12'h104, 8, 1'b0);
        checkpoint("single");

        send_frame(12'h104, 1, 1'b0);
        send_frame(12'hFFF, 8, 1'b0);
        checkpoint("back_to_back");

        // Truncated frame: space after the fifth bit never ends
        model_error();
        send_start(1'b0);
        send_bits(12'h555, 5, 1'b0);
        seg(1'b1, 20);
        checkpoint("space_timeout");

        seg(1'b0, 10);
        seg(1'b1, 8);
        checkpoint("noise_start");

        // Reset in the middle of a frame, then a clean frame
        send_start(1'b0);
        send_bits(12'h3C3, 4, 1'b0);
        bus.ir_signal = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        bus.ir_signal = 1'b1;
        reset = 1'b1;
        model_cmd = 12'h000;
        pend_v = 1'b0;
        checkpoint("mid_frame_reset");
        seg(1'b1, 8);
        send_frame(12'h2A5, 8, 1'b1);
        checkpoint("after_reset");

        for (int i = 0; i < 4; i++) send_frame(12'h104, 4, 1'b0);
        checkpoint("repeat_x4");
        send_frame(12'h104, 4, 1'b0);
        send_frame(12'h208, 4, 1'b0);
        checkpoint("repeat_mismatch");

        last_d = 12'h208;
        for (int t = 0; t < 25; t++) begin
            kind = rnd(0, 6);
            k = rnd(0, 11);
            d = (rnd(0, 1) == 1) ? last_d : 12'($urandom);
            case (kind)
                0, 1, 2: begin
                    send_frame(d, rnd(2, 10), 1'b1);
                    last_d = d;
                end
                3: begin
                    model_error();
                    send_start(1'b1);
                    send_bits(d, k, 1'b1);
                    seg(1'b1, rnd(13, 20));
                end
                4: begin
                    model_error();
                    send_start(1'b1);
                    send_bits(d, k, 1'b1);
                    seg(1'b1, rnd(1, 3));
                    seg(1'b0, rnd(4, 27));
                    seg(1'b1, rnd(2, 10));
                end
                5: begin
                    model_error();
                    send_start(1'b1);
                    send_bits(d, k, 1'b1);
                    seg(1'b1, rnd(4, 12));
                    seg(1'b0, (rnd(0, 1) == 1) ? rnd(1, 3) : rnd(28, 35));
                    seg(1'b1, rnd(2, 10));
                end
                default: begin
                    seg(1'b0, (rnd(0, 1) == 1) ? rnd(1, 27) : rnd(41, 60));
                    seg(1'b1, rnd(2, 10));
                end
            endcase
            checkpoint("random");
        end

        check_eq("expected_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
